// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants, FSM state encoding and word-level helpers.
package aes_pkg;

    localparam int unsigned AES_NR = 10;
    localparam int unsigned KEY_W  = 128;

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StExpand = 1'b1;

    // Round constants for rounds 1..10, round 1 in the most significant byte.
    localparam logic [79:0] RCON_TABLE = 80'h01_02_04_08_10_20_40_80_1b_36;

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] val;
        case (rnd)
            4'd1:    val = RCON_TABLE[79:72];
            4'd2:    val = RCON_TABLE[71:64];
            4'd3:    val = RCON_TABLE[63:56];
            4'd4:    val = RCON_TABLE[55:48];
            4'd5:    val = RCON_TABLE[47:40];
            4'd6:    val = RCON_TABLE[39:32];
            4'd7:    val = RCON_TABLE[31:24];
            4'd8:    val = RCON_TABLE[23:16];
            4'd9:    val = RCON_TABLE[15:8];
            4'd10:   val = RCON_TABLE[7:0];
            default: val = 8'h00;
        endcase
        return val;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // sub_rot is SubWord(RotWord(w3)) of the previous round key.
    function automatic logic [127:0] next_round_key(input logic [127:0] prev,
                                                    input logic [31:0]  sub_rot,
                                                    input logic [3:0]   rnd);
        logic [31:0] t, n0, n1, n2, n3;
        t  = sub_rot ^ {rcon(rnd), 24'h000000};
        n0 = prev[127:96] ^ t;
        n1 = n0 ^ prev[95:64];
        n2 = n1 ^ prev[63:32];
        n3 = n2 ^ prev[31:0];
        return {n0, n1, n2, n3};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] subst
);

    // Entry 0x00 sits in the top byte, so the table index is (255 - value).
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign subst = SBOX[{~value, 3'b000} +: 8];

endmodule

// File: rtl/aes128_key_expand_seq.sv
// Iterative AES-128 key schedule: one round key per clock into a held 11-entry key bank.
// Optional KEY_EXP_SKIP_SAME_EN: re-requesting the already-expanded key completes without expanding.
module aes128_key_expand_seq
    import aes_pkg::*;
#(
    parameter int unsigned NR = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [KEY_W-1:0]          key_in,
    output logic                      busy,
    output logic                      done,
    output logic                      keys_valid,
    output logic [(NR+1)*KEY_W-1:0]   round_keys
);

    if (NR != AES_NR) begin : g_nr_check
        $error("aes128_key_expand_seq supports NR = 10 only");
    end

    logic [0:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             valid_q, valid_d;
    logic             load_key, write_round, skip;
    logic [KEY_W-1:0] keys_q [NR+1];
    logic [KEY_W-1:0] prev_key, next_key;
    logic [31:0]      rot, sub_rot;

`ifdef KEY_EXP_SKIP_SAME_EN
    assign skip = valid_q && (key_in == keys_q[0]);
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        prev_key = '0;
        for (int i = 1; i <= NR; i++) begin
            if (cnt_q == 4'(i)) prev_key = keys_q[i-1];
        end
    end

    assign rot = rot_word(prev_key[31:0]);

    for (genvar g = 0; g < 4; g++) begin : g_sub_word
        aes_sbox u_sbox (
            .value (rot[8*g +: 8]),
            .subst (sub_rot[8*g +: 8])
        );
    end

    assign next_key = next_round_key(prev_key, sub_rot, cnt_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        valid_d     = valid_q;
        load_key    = 1'b0;
        write_round = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = 4'd0;
                if (start && skip) begin
                    done_d = 1'b1;
                end else if (start) begin
                    load_key = 1'b1;
                    cnt_d    = 4'd1;
                    busy_d   = 1'b1;
                    valid_d  = 1'b0;
                    state_d  = StExpand;
                end
            end
            StExpand: begin
                write_round = 1'b1;
                if (cnt_q == 4'(NR)) begin
                    cnt_d   = 4'd0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    // Entries not yet rewritten keep stale values; keys_valid guards the whole set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= NR; i++) keys_q[i] <= '0;
        end else begin
            if (load_key) keys_q[0] <= key_in;
            for (int i = 1; i <= NR; i++) begin
                if (write_round && cnt_q == 4'(i)) keys_q[i] <= next_key;
            end
        end
    end

    always_comb begin
        round_keys = '0;
        for (int i = 0; i <= NR; i++) round_keys[KEY_W*i +: KEY_W] = keys_q[i];
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign keys_valid = valid_q;

endmodule

// File: tb/tb_aes128_key_expand_seq.sv
// Directed bench for aes128_key_expand_seq using FIPS-197 and all-zero key schedules.
module tb_aes128_key_expand_seq;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_KEY = 128'h0;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

`ifdef KEY_EXP_SKIP_SAME_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [127:0]  key_in = '0;
    logic          busy, done, keys_valid;
    logic [1407:0] round_keys;

    int n_checks = 0;
    int n_fail   = 0;

    aes128_key_expand_seq #(
        .NR (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .round_keys (round_keys)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rk(input int n);
        return round_keys[128*n +: 128];
    endfunction

    task automatic pulse_start(input logic [127:0] k);
        key_in = k;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Edges after the start edge until done is seen; records busy levels seen before done.
    task automatic wait_done(output int edges, output bit busy_low, output bit busy_high);
        edges     = 0;
        busy_low  = 1'b0;
        busy_high = 1'b0;
        while (!done && edges < 30) begin
            if (busy) busy_high = 1'b1;
            else busy_low = 1'b1;
            tick();
            edges++;
        end
    endtask

    initial begin
        int e, pulses, done_at;
        bit bl, bh;

        // Reset state
        repeat (2) tick();
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_valid", 128'(keys_valid), 128'(0));
        check("rst_keys_zero", 128'(|round_keys), 128'(0));
        reset = 1'b1;
        tick();

        // FIPS-197 key, full expansion
        pulse_start(FIPS_KEY);
        check("fips_busy_after_start", 128'(busy), 128'(1));
        check("fips_valid_after_start", 128'(keys_valid), 128'(0));
        wait_done(e, bl, bh);
        check("fips_latency", 128'(e), 128'(10));
        check("fips_busy_held", 128'(bl), 128'(0));
        check("fips_busy_at_done", 128'(busy), 128'(0));
        check("fips_valid_at_done", 128'(keys_valid), 128'(1));
        check("fips_round0", rk(0), FIPS_KEY);
        check("fips_round1", rk(1), FIPS_R1);
        check("fips_round10", rk(10), FIPS_R10);

        // Back-to-back: zero key requested in the done cycle
        pulse_start(ZERO_KEY);
        check("b2b_valid_drop", 128'(keys_valid), 128'(0));
        check("b2b_busy", 128'(busy), 128'(1));
        check("b2b_done_single", 128'(done), 128'(0));
        wait_done(e, bl, bh);
        check("zero_latency", 128'(e), 128'(10));
        check("zero_round1", rk(1), ZERO_R1);
        check("zero_round10", rk(10), ZERO_R10);
        check("zero_valid", 128'(keys_valid), 128'(1));

        // start re-pulsed while busy with a different key
        pulse_start(FIPS_KEY);
        pulses  = 0;
        done_at = 0;
        for (int c = 1; c <= 14; c++) begin
            if (c == 3 || c == 7) begin
                key_in = ZERO_KEY;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                pulses++;
                done_at = c;
            end
        end
        start = 1'b0;
        check("repulse_done_count", 128'(pulses), 128'(1));
        check("repulse_done_cycle", 128'(done_at), 128'(10));
        check("repulse_round0", rk(0), FIPS_KEY);
        check("repulse_round1", rk(1), FIPS_R1);
        check("repulse_round10", rk(10), FIPS_R10);

        // Asynchronous reset in the middle of an expansion
        pulse_start(ZERO_KEY);
        repeat (4) tick();
        #2;
        reset = 1'b0;
        #1;
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_done", 128'(done), 128'(0));
        check("midrst_valid", 128'(keys_valid), 128'(0));
        check("midrst_keys_zero", 128'(|round_keys), 128'(0));
        #2;
        reset = 1'b1;
        tick();
        pulse_start(FIPS_KEY);
        wait_done(e, bl, bh);
        check("postrst_latency", 128'(e), 128'(10));
        check("postrst_round1", rk(1), FIPS_R1);
        check("postrst_round10", rk(10), FIPS_R10);

        // Same key requested again
        pulse_start(FIPS_KEY);
        check("same_busy_after_start", 128'(busy), SKIP ? 128'(0) : 128'(1));
        check("same_valid_after_start", 128'(keys_valid), SKIP ? 128'(1) : 128'(0));
        wait_done(e, bl, bh);
        check("same_latency", 128'(e), SKIP ? 128'(0) : 128'(10));
        check("same_busy_seen", 128'(bh), SKIP ? 128'(0) : 128'(1));
        check("same_busy_at_done", 128'(busy), 128'(0));
        check("same_valid_at_done", 128'(keys_valid), 128'(1));
        check("same_round10", rk(10), FIPS_R10);
        tick();
        check("same_done_single", 128'(done), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
